// File: rtl/mips_pkg.sv
// Shared MIPS datapath package: ISA field widths, field bit positions inside
// a 32-bit instruction word, and a few opcode/funct encodings.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 6;
  localparam int REG_ADDR_W = 5;
  localparam int SHAMT_W    = 5;
  localparam int FUNCT_W    = 6;
  localparam int IMM_W      = 16;
  localparam int JADDR_W    = 26;

  // Field bit positions (MSB/LSB inclusive)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  // Opcode / funct encodings
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J      = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_LW     = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW     = 6'h2B;
  localparam logic [FUNCT_W-1:0]  FUNCT_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0]  FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0]  FUNCT_SUB = 6'h22;

endpackage

// File: rtl/ir_field_split.sv
// ir_field_split: purely combinational slicing of a 32-bit instruction word
// into the MIPS fields. Fields overlap; every one is always driven whatever
// the instruction format.
// Optional macro IR_SHAMT_EN adds the shamt output.
// Ports:
//   word        in  32  instruction word to slice
//   opcode      out 6   word[31:26]
//   rs,rt,rd    out 5   word[25:21], word[20:16], word[15:11]
//   shamt       out 5   word[10:6] (IR_SHAMT_EN only)
//   funct       out 6   word[5:0]
//   immediate   out 16  word[15:0]
//   jumpAddress out 26  word[25:0]
module ir_field_split
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0]    word,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
`ifdef IR_SHAMT_EN
  output logic [SHAMT_W-1:0]    shamt,
`endif
  output logic [FUNCT_W-1:0]    funct,
  output logic [IMM_W-1:0]      immediate,
  output logic [JADDR_W-1:0]    jumpAddress
);

  assign opcode      = word[OPCODE_MSB:OPCODE_LSB];
  assign rs          = word[RS_MSB:RS_LSB];
  assign rt          = word[RT_MSB:RT_LSB];
  assign rd          = word[RD_MSB:RD_LSB];
`ifdef IR_SHAMT_EN
  assign shamt       = word[SHAMT_MSB:SHAMT_LSB];
`endif
  assign funct       = word[FUNCT_MSB:FUNCT_LSB];
  assign immediate   = word[IMM_MSB:IMM_LSB];
  assign jumpAddress = word[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/reg_instruccion.sv
// reg_instruccion: instruction register of the multicycle MIPS datapath.
// Captures the fetched word when ir_w is high and holds it for the rest of
// the instruction. All outputs slice the stored word, never the live input,
// so they only move on a load edge or on reset.
// Optional macro IR_SHAMT_EN adds the shamt output.
// Ports:
//   clk         in  1   system clock, rising edge
//   rst_n       in  1   asynchronous active-low reset, clears the register
//   instruction in  32  word from memory
//   ir_w        in  1   load enable
//   jumpAddress out 26, opcode out 6, rs/rt/rd out 5, funct out 6,
//   immediate out 16, shamt out 5 (IR_SHAMT_EN only)
module reg_instruccion
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  ir_w,
  output logic [JADDR_W-1:0]    jumpAddress,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
`ifdef IR_SHAMT_EN
  output logic [SHAMT_W-1:0]    shamt,
`endif
  output logic [FUNCT_W-1:0]    funct,
  output logic [IMM_W-1:0]      immediate
);

  logic [INSTR_W-1:0] ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ir_q <= '0;
    else if (ir_w) ir_q <= instruction;
  end

  ir_field_split u_split (
    .word        (ir_q),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
`ifdef IR_SHAMT_EN
    .shamt       (shamt),
`endif
    .funct       (funct),
    .immediate   (immediate),
    .jumpAddress (jumpAddress)
  );

endmodule

// File: tb/tb_reg_instruccion.sv
// Directed bench for reg_instruccion: reset, R-type load, back-to-back load,
// hold, asynchronous reset mid-run, reset-over-enable, optional shamt.
module tb_reg_instruccion;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction = '0;
  logic        ir_w = 1'b0;
  logic [25:0] jumpAddress;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] immediate;
`ifdef IR_SHAMT_EN
  logic [4:0]  shamt;
`endif

  int total = 0;
  int bad   = 0;

  // {opcode, rs, rt, rd, funct, immediate, jumpAddress} = 69 bits
  logic [68:0] obs;
  assign obs = {opcode, rs, rt, rd, funct, immediate, jumpAddress};

  reg_instruccion dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .ir_w        (ir_w),
    .jumpAddress (jumpAddress),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
`ifdef IR_SHAMT_EN
    .shamt       (shamt),
`endif
    .funct       (funct),
    .immediate   (immediate)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst_n = 1'b0;
    instruction = 32'hFFFF_FFFF;
    ir_w = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_hold obs=%h want=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    ir_w = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_release obs=%h want=0", obs); end
  endtask

  task automatic test_rtype();
    @(negedge clk);
    instruction = 32'h0030_0020;
    ir_w = 1'b1;
    @(posedge clk); #1;
    total++; if (opcode !== OP_RTYPE) begin bad++; $display("FAIL rtype_opcode got=%h want=%h", opcode, OP_RTYPE); end
    total++; if (rs !== 5'd1) begin bad++; $display("FAIL rtype_rs got=%0d want=1", rs); end
    total++; if (rt !== 5'd16) begin bad++; $display("FAIL rtype_rt got=%0d want=16", rt); end
    total++; if (rd !== 5'd0) begin bad++; $display("FAIL rtype_rd got=%0d want=0", rd); end
    total++; if (funct !== FUNCT_ADD) begin bad++; $display("FAIL rtype_funct got=%h want=%h", funct, FUNCT_ADD); end
    total++; if (immediate !== 16'h0020) begin bad++; $display("FAIL rtype_imm got=%h want=0020", immediate); end
    total++; if (jumpAddress !== 26'h030_0020) begin bad++; $display("FAIL rtype_jaddr got=%h want=0300020", jumpAddress); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instruction = 32'h1000_0030;  // ir_w left high from the previous load
    @(posedge clk); #1;
    total++;
    if (obs !== {OP_BEQ, 5'd0, 5'd0, 5'd0, 6'h30, 16'h0030, 26'h000_0030}) begin
      bad++; $display("FAIL b2b_beq obs=%h op=%h funct=%h imm=%h", obs, opcode, funct, immediate);
    end
  endtask

  task automatic test_hold();
    logic [68:0] exp_hold;
    exp_hold = {OP_BEQ, 5'd0, 5'd0, 5'd0, 6'h30, 16'h0030, 26'h000_0030};
    @(negedge clk);
    ir_w = 1'b0;
    instruction = 32'hDEAD_BEEF;
    #1;
    total++;
    if (obs !== exp_hold) begin bad++; $display("FAIL hold_comb obs=%h want=%h", obs, exp_hold); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_hold) begin bad++; $display("FAIL hold_edge%0d obs=%h want=%h", i, obs, exp_hold); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    instruction = 32'h8C22_0004;  // lw $2, 4($1)
    ir_w = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== {OP_LW, 5'd1, 5'd2, 5'd0, 6'h04, 16'h0004, 26'h022_0004}) begin
      bad++; $display("FAIL lw_load obs=%h op=%h rs=%0d rt=%0d", obs, opcode, rs, rt);
    end
    ir_w = 1'b0;
    #2 rst_n = 1'b0;  // between edges
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL async_reset obs=%h want=0", obs); end
  endtask

  task automatic test_reset_dominates();
    @(negedge clk);
    instruction = 32'h1234_5678;
    ir_w = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_dominates obs=%h want=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    instruction = 32'h0030_0020;
    @(posedge clk); #1;
    total++;
    if (obs !== {OP_RTYPE, 5'd1, 5'd16, 5'd0, FUNCT_ADD, 16'h0020, 26'h030_0020}) begin
      bad++; $display("FAIL first_load_after_release obs=%h", obs);
    end
  endtask

`ifdef IR_SHAMT_EN
  task automatic test_shamt();
    @(negedge clk);
    instruction = 32'h0002_15C0;  // sll $2, $2, 23
    ir_w = 1'b1;
    @(posedge clk); #1;
    total++; if (shamt !== 5'd23) begin bad++; $display("FAIL shamt got=%0d want=23", shamt); end
    total++; if (rd !== 5'd2) begin bad++; $display("FAIL shamt_rd got=%0d want=2", rd); end
    total++; if (funct !== FUNCT_SLL) begin bad++; $display("FAIL shamt_funct got=%h want=0", funct); end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_reset_dominates();
`ifdef IR_SHAMT_EN
    test_shamt();
`endif
    @(negedge clk);
    ir_w = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_instruccion.md
# reg_instruccion

Instruction register of the multicycle MIPS-style datapath. It captures the 32-bit word fetched from memory when the control unit asserts the write enable. It holds that word across the remaining cycles of the instruction. It exposes the standard MIPS field slices (opcode, rs, rt, rd, funct, immediate, jump target) to the control unit, the register file and the immediate/jump logic.

## Interface
- Parameters: none (field widths are fixed by the ISA; see Structure).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction` in 32: word from instruction/data memory.
- `ir_w` in 1: write enable from the control unit; 1 = load `instruction` on the next rising edge.
- `jumpAddress` out 26: stored[25:0].
- `opcode` out 6: stored[31:26].
- `rs` out 5: stored[25:21].
- `rt` out 5: stored[20:16].
- `rd` out 5: stored[15:11].
- `funct` out 6: stored[5:0].
- `immediate` out 16: stored[15:0].
- `shamt` out 5: stored[10:6]; present only with `IR_SHAMT_EN`.

## Operation
- Single 32-bit storage register `ir_q`.
- `rst_n` = 0: `ir_q` cleared to 0 immediately, independent of `clk`.
- With reset released, all outputs are 0 (opcode 0, funct 0, all fields 0).
- Rising edge of `clk` with `ir_w` = 1: `ir_q` <= `instruction`.
- Rising edge with `ir_w` = 0: `ir_q` holds.
- All outputs are purely combinational slices of `ir_q`, never of `instruction`. Outputs therefore change only on a load edge or on reset.
- Fields overlap by design: `immediate` contains `rd`/`shamt`/`funct`, and `jumpAddress` contains `rs`/`rt`/`immediate`. Every field is always driven, regardless of instruction format.
- No sign extension or shifting of `immediate`/`jumpAddress`. That is done downstream.

## Timing
- Load latency: 1 clock. Outputs reflect the new word immediately after the rising edge where `ir_w` = 1 was sampled.
- `ir_w` held high for consecutive cycles loads on every edge. The last sampled word wins.
- `instruction` and `ir_w` must meet setup/hold around the rising edge. Benches change them mid-cycle, away from the edge.
- Reset asserted mid-operation clears `ir_q` asynchronously.
- Reset deassertion is synchronised externally. The first load can occur on the first edge after release.
- Reset and `ir_w` both active: reset dominates.

## Configuration
- Macro `IR_SHAMT_EN`.
  - Defined: adds the `shamt` output port (stored[10:6]).
  - Undefined: the port does not exist, and the behaviour of all other ports is identical.

## Structure
- A shared package `mips_pkg` holds:
  - Width constants: `INSTR_W` = 32, `OPCODE_W` = 6, `REG_ADDR_W` = 5, `FUNCT_W` = 6, `IMM_W` = 16, `JADDR_W` = 26.
  - Field bit-position constants (e.g. `OPCODE_MSB`/`LSB`, `RS_MSB`/`LSB`, …).
  - Opcode/funct constants used by the bench (e.g. `OP_RTYPE` = 6'h00, `OP_BEQ` = 6'h04, `FUNCT_ADD` = 6'h20).
- One sub-module, `ir_field_split`: purely combinational slicing of a 32-bit word into the fields. The top module holds only the enable register plus that sub-module.

## Test plan
- Reset: assert `rst_n` = 0 with `instruction` = 32'hFFFFFFFF and `ir_w` = 1 -> all outputs 0; release with `ir_w` = 0 -> outputs stay 0.
- R-type load: `instruction` = 32'h00300020, `ir_w` = 1, one edge -> `opcode` 0, `rs` 1, `rt` 16, `rd` 0, `funct` 6'h20, `immediate` 16'h0020, `jumpAddress` 26'h0300020.
- Back-to-back load: next cycle `instruction` = 32'h10000030, `ir_w` still 1 -> `opcode` 4, `rs`/`rt`/`rd` 0, `funct` 6'h30, `immediate` 16'h0030, `jumpAddress` 26'h0000030.
- Hold: `ir_w` = 0 and `instruction` changed to 32'hDEADBEEF for 3 edges -> outputs unchanged from the previous load.
- Async reset mid-run: drop `rst_n` between edges after a load -> outputs 0 before the next edge.
- With `IR_SHAMT_EN`: load 32'h000215C0 -> `shamt` 5'd23, `rd` 2, `funct` 0.
